// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, low chunk first,
// with a valid/ready handshake on both the operand and the result side.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CH     = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK = WIDTH / CH;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  generate
    if (CHUNK < 1) begin : g_bad_chunk
      $error("seq_chunk_adder: CHUNK must be at least 1");
    end else if ((WIDTH % CH) != 0 || WIDTH < CH) begin : g_bad_width
      $error("seq_chunk_adder: WIDTH must be an exact multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry;
  logic [IW-1:0]     idx;

  logic [31:0]       base;
  logic [CH-1:0]     a_ch;
  logic [CH-1:0]     b_ch;
  logic [CH-1:0]     sum_ch;
  logic              c_next;
  logic              msb_cin;

  function automatic logic [CH:0] chunk_add(input logic [CH-1:0] x,
                                            input logic [CH-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CH{1'b0}}, c};
  endfunction

  always_comb begin
    base              = 32'(idx) * CH;
    a_ch              = a_q[base +: CH];
    b_ch              = b_q[base +: CH];
    {c_next, sum_ch}  = chunk_add(a_ch, b_ch, carry);
    // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
    msb_cin           = a_ch[CH-1] ^ b_ch[CH-1] ^ sum_ch[CH-1];
  end

  // Operand capture: data only, written solely on the accept edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
  end

  // Control and result state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          s[base +: CH] <= sum_ch;
          carry         <= c_next;
          idx           <= idx + IW'(1);
          if (idx == LAST) begin
            cout  <= c_next;
            ovf   <= msb_cin ^ c_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning operands presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning block accepts operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-008 The block SHALL have port cin, input, 1 bit, carry-in; ignored when sub=1.
REQ-009 The block SHALL have port sub, input, 1 bit, where 0 selects a+b+cin and 1 selects a-b.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning result available.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning consumer takes the result.
REQ-012 The block SHALL have port s, output, WIDTH bits, the sum or difference.
REQ-013 The block SHALL have port cout, output, 1 bit, the carry out of the MSB; for sub, 1 = no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit, two's-complement signed overflow.
REQ-015 The block SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-016 The block SHALL reject at elaboration any WIDTH not an exact multiple of CHUNK, and any CHUNK < 1.
REQ-017 The block SHALL implement states IDLE, ADD and DONE, with in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-018 In IDLE, on in_valid&&in_ready, the block SHALL latch a, b' = (sub ? ~b : b), carry = (sub ? 1 : cin), clear the chunk index and go to ADD.
REQ-019 In ADD, each cycle SHALL add chunk i of a and b' plus the carry register, write the CHUNK-bit result into slice i of s, update the carry, and increment i.
REQ-020 The ADD-to-DONE transition SHALL occur on the edge processing chunk NCHUNK-1, so out_valid rises exactly NCHUNK cycles after the accepting edge.
REQ-021 On the final chunk the block SHALL set cout to the carry out of bit WIDTH-1 and ovf to the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-022 In DONE, s, cout and ovf SHALL hold stable while out_ready=0, and the block SHALL return to IDLE on the edge where out_ready=1.
REQ-023 in_valid while busy SHALL be ignored, with no change to the latched operands.
REQ-024 s, cout and ovf SHALL retain the last result in IDLE until the next accept overwrites slices in ADD.
REQ-025 Operand inputs SHALL be sampled only on the accept edge; later changes to them SHALL not affect the result in progress.

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE, with s=0, cout=0, ovf=0, carry=0, index=0, out_valid=0, busy=0 and in_ready=1.
REQ-027 Reset asserted in ADD or DONE SHALL abort the operation immediately, with no result delivered.

Verification (WIDTH=16, CHUNK=4)
REQ-028 a=0x00FF, b=0x0001, cin=0, sub=0 accepted at edge k -> out_valid at edge k+4, s=0x0100, cout=0, ovf=0.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, cout=0, ovf=1.
REQ-030 sub=1, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0; sub=1, a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-031 out_ready held 0 for 5 cycles in DONE -> s, cout and ovf constant, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-032 rst_n pulsed low two cycles after accept -> all outputs zero, in_ready=1, out_valid never asserted for that operation.
REQ-033 An exhaustive sweep with WIDTH=4, CHUNK=1 over all a, b, cin, sub SHALL match the reference model for s, cout and ovf, with a latency of 4 cycles each.
